// File: rtl/altair_mux_pkg.sv
// Shared definitions for the altair one-hot mux/demux family.
// Default widths, lane slot states and the one-hot select check.
package altair_mux_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_LANES     = 4;
    localparam int unsigned DEF_ERR_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Exactly one bit set; zero or multiple bits is a select error.
    function automatic logic is_onehot4(input logic [3:0] sel);
        return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/special_demux_1_4_if.sv
// Source handshake plus per-lane destination handshakes of the 1:4 demux.
// The master drives the source word and the consumers' ready lines.
interface special_demux_1_4_if
    import altair_mux_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
);

    logic                 i_valid;
    logic                 o_ready;
    logic [LANES-1:0]     i_selection;
    logic [DATA_W-1:0]    i_data;
    logic [LANES-1:0]     o_valid;
    logic [LANES-1:0]     i_ready;
    logic [DATA_W-1:0]    o_outputs [LANES-1:0];
    logic                 o_en;
    logic                 o_error_selection;
    logic [ERR_CNT_W-1:0] o_err_count;

    modport master (
        output i_valid, i_selection, i_data, i_ready,
        input  o_ready, o_valid, o_outputs, o_en, o_error_selection, o_err_count
    );

    modport slave (
        input  i_valid, i_selection, i_data, i_ready,
        output o_ready, o_valid, o_outputs, o_en, o_error_selection, o_err_count
    );

endinterface

// File: rtl/demux_lane_slot.sv
// Single-entry register slot for one destination lane.
// A load on the same edge as a drain replaces the word without a bubble.
module demux_lane_slot
    import altair_mux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    slot_state_e       state_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            if (load_i) begin
                data_q <= data_i;
            end
            unique case (state_q)
                SLOT_EMPTY: if (load_i) state_q <= SLOT_FULL;
                SLOT_FULL:  if (ready_i && !load_i) state_q <= SLOT_EMPTY;
                default:    state_q <= SLOT_EMPTY;
            endcase
        end
    end

    // Data is left in place after a drain.
    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/special_demux_1_4.sv
// One-hot selected 1:4 dispatcher: decodes the select, steers accepted words
// into per-lane slots and drops words with a bad select, counting them.
module special_demux_1_4
    import altair_mux_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
    input logic               i_clk,
    input logic               i_rst,
    special_demux_1_4_if.slave bus
);

    logic                 sel_onehot;
    logic                 ready_c;
    logic                 accept;
    logic [LANES-1:0]     lane_load;
    logic [LANES-1:0]     lane_valid;
    logic [DATA_W-1:0]    lane_data [LANES-1:0];
    logic                 err_d;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign sel_onehot = is_onehot4(bus.i_selection);

    // Bad selects are always taken so they can be dropped; good ones wait on their lane.
    always_comb begin
        ready_c = 1'b1;
        if (sel_onehot) begin
            ready_c = |(bus.i_selection & (~lane_valid | bus.i_ready));
        end
    end

    assign bus.o_ready = ready_c & ~i_rst;
    assign accept      = bus.i_valid & bus.o_ready;
    assign lane_load   = (accept && sel_onehot) ? bus.i_selection : '0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        demux_lane_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .load_i  (lane_load[g]),
            .data_i  (bus.i_data),
            .ready_i (bus.i_ready[g]),
            .valid_o (lane_valid[g]),
            .data_o  (lane_data[g])
        );
    end

    always_comb begin
        err_d     = accept & ~sel_onehot;
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_valid           = lane_valid;
    assign bus.o_outputs         = lane_data;
    assign bus.o_en              = |lane_valid;
    assign bus.o_error_selection = err_q;
    assign bus.o_err_count       = err_cnt_q;

endmodule
